// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit-queue FSM state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } tx_q_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO: circular buffer, wrapping read/write pointers, occupancy count.
// Latency: a pushed word is visible at o_head / o_count one cycle after the push.
// Backpressure: a push while full or a pop while empty is ignored; the caller sees o_count.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_push, i_push_dat      write strobe and data
//   i_pop                   read strobe (advances the head)
//   o_head                  word at the head of the queue
//   o_count                 occupancy, 0..DEPTH
module uart_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // The count (one bit wider than the pointers) disambiguates full from empty
    // when the pointers are equal.
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop  & ~w_empty;

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of a UART sender: buffers writes and issues one request per byte.
// Latency: write into an empty idle queue at N -> pop at N+1 -> uart_en/uart_din at N+2.
// Backpressure: writes while full are dropped (wr_drop pulses); bytes drain when uart_idle=1.
//
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   wr_en, wr_data          byte write strobe and data
//   full, empty, wr_drop    queue status; wr_drop flags a discarded write, one cycle late
//   uart_idle               sender ready (no frame in progress)
//   uart_en, uart_din       send request (sender acts on rising edge) and byte
//   level                   occupancy, only when UART_TX_QUEUE_LEVEL_EN is defined
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic                   wr_drop,
    input  logic                   uart_idle,
    output logic                   uart_en,
    output logic [UART_DATA_W-1:0] uart_din
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int AW = $clog2(DEPTH);

    tx_q_state_t            r_state;
    tx_q_state_t            w_state_nxt;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [UART_DATA_W-1:0] w_head;
    logic [AW:0]            w_count;
    logic                   r_uart_en;
    logic [UART_DATA_W-1:0] r_uart_din;
    logic                   r_wr_drop;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_push     (wr_en),
        .i_push_dat (wr_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign w_full  = (w_count == (AW+1)'(DEPTH));
    assign w_empty = (w_count == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && uart_idle) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (!uart_idle) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (uart_idle) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // uart_en tracks the next state so it is high exactly while in S_REQ. The
    // mandatory S_BUSY plus S_IDLE visit keeps it low for at least two cycles
    // between requests.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_uart_en  <= 1'b0;
            r_uart_din <= '0;
            r_wr_drop  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_uart_en <= (w_state_nxt == S_REQ);
            if (w_pop) begin
                r_uart_din <= w_head;
            end
            r_wr_drop <= wr_en & w_full;
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign wr_drop  = r_wr_drop;
    assign uart_en  = r_uart_en;
    assign uart_din = r_uart_din;

`ifdef UART_TX_QUEUE_LEVEL_EN
    assign level = w_count;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue (DEPTH=16): cycle table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: a modelled sender drops uart_idle for FRAME cycles after each request.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int FRAME = 6;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       wr_drop;
    logic       uart_idle;
    logic       uart_en;
    logic [7:0] uart_din;
`ifdef UART_TX_QUEUE_LEVEL_EN
    logic [4:0] level;
`endif

    logic       man_idle;
    logic       sender_on;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .wr_drop   (wr_drop),
        .uart_idle (uart_idle),
        .uart_en   (uart_en),
        .uart_din  (uart_din)
`ifdef UART_TX_QUEUE_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    // Sender model: records the byte on each rising uart_en, then stays busy.
    logic       prev_en  = 1'b0;
    int         busy_cnt = 0;
    int         drops    = 0;
    logic [7:0] cap[$];

    assign uart_idle = sender_on ? (busy_cnt == 0) : man_idle;

    always @(posedge sys_clk) begin
        prev_en <= uart_en;
        if (uart_en && !prev_en) begin
            cap.push_back(uart_din);
            busy_cnt <= FRAME;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (wr_drop) begin
            drops <= drops + 1;
        end
    end

    typedef struct packed {
        logic       rst;
        logic       wr;
        logic [7:0] dat;
        logic       idle;
        logic       e_full;
        logic       e_empty;
        logic       e_drop;
        logic       e_en;
        logic [7:0] e_din;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int idx);
        if (idx < cap.size()) return {24'h0, cap[idx]};
        return 32'hDEAD;
    endfunction

    task automatic do_reset();
        sys_rst = 1'b1;
        wr_en   = 1'b0;
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic wait_cap(input string name, input int n, input int budget);
        int c = 0;
        while (cap.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk(name, cap.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        int n;
        int cyc;

        sys_rst   = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        man_idle  = 1'b1;
        sender_on = 1'b0;

        //           rst   wr    dat    idle  full  empty drop  en    din
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}; // reset beats write
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}; // write at N
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5}; // request at N+2
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5}; // hold in S_REQ
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}; // -> S_BUSY
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5}; // -> S_IDLE
        vecs[8]  = '{1'b0, 1'b1, 8'hB6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB6};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB6};
        vecs[11] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB6}; // write in S_BUSY
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hC3};

        #1;
        for (int i = 0; i < 13; i++) begin
            sys_rst  = vecs[i].rst;
            wr_en    = vecs[i].wr;
            wr_data  = vecs[i].dat;
            man_idle = vecs[i].idle;
            tick();
            chk($sformatf("vec%0d full", i),  full,     vecs[i].e_full);
            chk($sformatf("vec%0d empty", i), empty,    vecs[i].e_empty);
            chk($sformatf("vec%0d drop", i),  wr_drop,  vecs[i].e_drop);
            chk($sformatf("vec%0d en", i),    uart_en,  vecs[i].e_en);
            chk($sformatf("vec%0d din", i),   uart_din, vecs[i].e_din);
        end
        wr_en = 1'b0;

        // Single byte with a long frame: one request only.
        do_reset();
        man_idle = 1'b1;
        base     = cap.size();
        wr_data  = 8'hA5;
        wr_en    = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
        chk("s1 en rise", uart_en, 1);
        chk("s1 din", uart_din, 8'hA5);
        man_idle = 1'b0;
        repeat (100) tick();
        chk("s1 en low while busy", uart_en, 0);
        man_idle = 1'b1;
        repeat (20) tick();
        chk("s1 bytes sent", cap.size() - base, 1);
        chk("s1 byte", cap_at(base), 8'hA5);
        chk("s1 empty", empty, 1);

        // Fill to full, overflow drop, then drain in order.
        do_reset();
        man_idle = 1'b0;
        base     = cap.size();
        dbase    = drops;
        for (int i = 1; i <= DEPTH; i++) begin
            wr_data = 8'(i);
            wr_en   = 1'b1;
            tick();
            if (i == DEPTH - 1) chk("s2 not full at 15", full, 0);
        end
        chk("s2 full at 16", full, 1);
`ifdef UART_TX_QUEUE_LEVEL_EN
        chk("s2 level 16", level, 16);
`endif
        wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        chk("s2 drop pulse", wr_drop, 1);
        chk("s2 still full", full, 1);
        tick();
        chk("s2 drop cleared", wr_drop, 0);
        sender_on = 1'b1;
        wait_cap("s2 drain count", base + DEPTH, 3000);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("s2 byte%0d", i), cap_at(base + i), 32'(i + 1));
        end
        repeat (30) tick();
        chk("s2 no extra byte", cap.size() - base, DEPTH);
        chk("s2 empty after drain", empty, 1);
        chk("s2 one drop", drops - dbase, 1);
        sender_on = 1'b0;

        // Push and pop in the same cycle at occupancy 5.
        do_reset();
        man_idle = 1'b0;
        base     = cap.size();
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'h50 + 8'(i);
            wr_en   = 1'b1;
            tick();
        end
        wr_data  = 8'h55;
        man_idle = 1'b1;
        tick();
        wr_en    = 1'b0;
        man_idle = 1'b0;
`ifdef UART_TX_QUEUE_LEVEL_EN
        chk("s3 level 5", level, 5);
`endif
        chk("s3 en", uart_en, 1);
        chk("s3 head popped", uart_din, 8'h50);
        chk("s3 not empty", empty, 0);
        sender_on = 1'b1;
        wait_cap("s3 drain count", base + 6, 1000);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("s3 byte%0d", i), cap_at(base + i), 32'(8'h50 + i));
        end
        sender_on = 1'b0;

        // Pointer wrap: 40 bytes through the queue with a modelled sender.
        do_reset();
        sender_on = 1'b1;
        base      = cap.size();
        dbase     = drops;
        n         = 0;
        cyc       = 0;
        while (n < 40 && cyc < 5000) begin
            if (!full) begin
                wr_data = 8'h80 + 8'(n);
                wr_en   = 1'b1;
                n++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        chk("s4 all written", n, 40);
        wait_cap("s4 drain count", base + 40, 3000);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("s4 byte%0d", i), cap_at(base + i), 32'(8'h80 + i));
        end
        chk("s4 no drops", drops - dbase, 0);
        sender_on = 1'b0;

        // Reset while in S_REQ with 3 bytes still queued.
        do_reset();
        man_idle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'h61 + 8'(i);
            wr_en   = 1'b1;
            tick();
        end
        wr_en    = 1'b0;
        man_idle = 1'b1;
        tick();
        chk("s5 in S_REQ", uart_en, 1);
`ifdef UART_TX_QUEUE_LEVEL_EN
        chk("s5 level 3", level, 3);
`endif
        tick();
        sys_rst = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        tick();
        chk("s5 rst en", uart_en, 0);
        chk("s5 rst empty", empty, 1);
        chk("s5 rst din", uart_din, 8'h00);
        chk("s5 rst full", full, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
        chk("s5 rst level", level, 0);
`endif
        sys_rst = 1'b0;
        wr_en   = 1'b0;
        base    = cap.size();
        repeat (20) tick();
        chk("s5 no stale byte", cap.size() - base, 0);
        chk("s5 still empty", empty, 1);
        chk("s5 en stays low", uart_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2 to 256.
REQ-002 sys_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 sys_rst  in  1  synchronous, active-high reset; SHALL be sampled only on the sys_clk rising edge.
REQ-004 wr_en  in  1  write strobe; each high cycle SHALL be one byte.
REQ-005 wr_data  in  8  byte to queue; sampled when wr_en=1.
REQ-006 full  out  1  high when the queue holds DEPTH entries.
REQ-007 empty  out  1  high when the queue holds 0 entries.
REQ-008 wr_drop  out  1  single-cycle pulse when a write is discarded.
REQ-009 uart_idle  in  1  transmitter-ready input from the downstream sender; high = no frame in progress.
REQ-010 uart_en  out  1  send request to the sender, which acts on its rising edge.
REQ-011 uart_din  out  8  byte presented to the sender.
REQ-012 level  out  $clog2(DEPTH)+1  occupancy; present only under UART_TX_QUEUE_LEVEL_EN.

Function
REQ-013 Queue SHALL be first-in first-out; bytes leave in write order, unmodified.
REQ-014 Write with wr_en=1 and full=0 SHALL store wr_data; full/empty SHALL update the next cycle.
REQ-015 Write with wr_en=1 and full=1 SHALL be dropped, contents unchanged, wr_drop=1 the next cycle; this holds even if a pop occurs the same cycle.
REQ-016 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from an extra pointer bit or a count, never ambiguous.
REQ-017 A simultaneous push (not full) and pop SHALL leave occupancy unchanged.
REQ-018 FSM states SHALL be S_IDLE, S_REQ and S_BUSY.
REQ-019 S_IDLE: if empty=0 and uart_idle=1, pop the head into the uart_din register and go to S_REQ; otherwise stay.
REQ-020 S_REQ: uart_en=1; stay until uart_idle=0, then go to S_BUSY.
REQ-021 S_BUSY: uart_en=0; stay until uart_idle=1, then go to S_IDLE.
REQ-022 uart_en SHALL be registered and high only in S_REQ.
REQ-023 uart_din SHALL stay stable from entry to S_REQ until the next pop.
REQ-024 Latency: write in an empty, idle queue at cycle N; empty falls at N+1; pop at N+1; uart_en=1 and uart_din valid at N+2.
REQ-025 uart_en SHALL be low for at least 2 consecutive cycles between requests, guaranteed by S_BUSY.
REQ-026 Writes SHALL be accepted in every FSM state.

Reset
REQ-027 On sys_rst: pointers and count cleared, empty=1, full=0, wr_drop=0, uart_en=0, uart_din=8'h00, level=0, state S_IDLE.
REQ-028 Reset mid-frame SHALL discard all queued bytes and the in-flight request; the sender's in-progress frame is not the queue's concern.
REQ-029 sys_rst SHALL override same-cycle writes.

Configuration
REQ-030 Macro UART_TX_QUEUE_LEVEL_EN defined: the level port exists and equals occupancy, updating one cycle after push/pop.
REQ-031 Macro UART_TX_QUEUE_LEVEL_EN undefined: the level port and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Shared package uart_pkg SHALL hold UART_DATA_W=8 and the FSM state typedef tx_q_state_t.
REQ-033 Storage and pointers SHALL be the sub-module uart_sync_fifo (parameters DEPTH and width); the FSM stays in uart_tx_queue.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Write 8'hA5 while empty with uart_idle=1 -> uart_en rises 2 cycles later, uart_din=8'hA5; hold uart_idle=0 for 100 cycles -> uart_en falls and exactly one byte is sent.
- Write 8'h01..8'h10 (DEPTH=16) back-to-back with uart_idle=0 -> full=1 after the 16th; a 17th write 8'hFF gives wr_drop=1; bytes 01..10 are later sent in order and 8'hFF never appears.
- Push and pop in the same cycle at occupancy 5 -> occupancy stays 5 (level=5 when UART_TX_QUEUE_LEVEL_EN is defined).
- Pointer wrap: 40 bytes through DEPTH=16 with a modelled sender -> all 40 bytes in order, no drops.
- Assert sys_rst while in S_REQ with 3 bytes queued -> next cycle uart_en=0, empty=1, uart_din=8'h00; no stale byte sent afterward.
- Build without UART_TX_QUEUE_LEVEL_EN -> compiles without the level port, and the scenarios above pass.
